// File: rtl/buzzer_sequencer.sv
// Beep pattern scheduler for the tone buzzer: fixed-priority grant among four
// requesters, then timed on/off gating of a one-hot tone select.
module buzzer_sequencer #(
  parameter int TICK_DIV  = 50_000,
  parameter int ON_TICKS  = 100,
  parameter int OFF_TICKS = 100
) (
  input  logic        clk_sel,
  input  logic        sys_rst_n,
  input  logic [3:0]  req_i,
  input  logic [7:0]  req_tone_i,
  input  logic [11:0] req_beeps_i,
  input  logic        abort_i,
  output logic [3:0]  ack_o,
  output logic        busy_o,
  output logic [1:0]  owner_o,
  output logic [3:0]  tone_sel_o,
  output logic        beep_en_o,
  output logic        done_o
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      tone_q, tone_d;
  logic [2:0]      remaining_q, remaining_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   ticks_q, ticks_d;
  logic [3:0]      ack_q, ack_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            beep_en_q, beep_en_d;
  logic [3:0]      tone_sel_q, tone_sel_d;

  logic            tick_w;
  logic            grant_valid_w;
  logic [1:0]      grant_idx_w;
  logic [1:0]      grant_tone_w;
  logic [2:0]      grant_beeps_w;

  function automatic logic [3:0] decode_tone(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  assign tick_w = (presc_q == PRESC_LAST);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    grant_valid_w = |req_i;
    grant_idx_w   = 2'd0;
    grant_tone_w  = 2'd0;
    grant_beeps_w = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_idx_w   = 2'(i);
        grant_tone_w  = req_tone_i[2*i +: 2];
        grant_beeps_w = req_beeps_i[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    tone_d      = tone_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    ticks_d     = ticks_q;
    ack_d       = 4'b0000;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid_w) begin
          owner_d            = grant_idx_w;
          tone_d             = grant_tone_w;
          ack_d[grant_idx_w] = 1'b1;
          presc_d            = '0;
          ticks_d            = '0;
          if (grant_beeps_w != 3'd0) begin
            state_d     = ON;
            remaining_d = grant_beeps_w;
          end
        end
      end

      ON: begin
        if (abort_i) begin
          state_d = IDLE;
          presc_d = '0;
          ticks_d = '0;
        end else if (tick_w) begin
          presc_d = '0;
          if (ticks_q == ON_LAST) begin
            ticks_d     = '0;
            remaining_d = remaining_q - 3'd1;
            state_d     = OFF;
          end else begin
            ticks_d = ticks_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      OFF: begin
        if (abort_i) begin
          state_d = IDLE;
          presc_d = '0;
          ticks_d = '0;
        end else if (tick_w) begin
          presc_d = '0;
          if (ticks_q == OFF_LAST) begin
            ticks_d = '0;
            if (remaining_q != 3'd0) begin
              state_d = ON;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            ticks_d = ticks_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
        ticks_d = '0;
      end
    endcase

    // Outputs are computed from the next state so they are registered yet aligned with it.
    busy_d     = (state_d != IDLE);
    beep_en_d  = (state_d == ON);
    tone_sel_d = (state_d == ON) ? decode_tone(tone_d) : 4'b0000;
  end

  always_ff @(posedge clk_sel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      tone_q      <= 2'd0;
      remaining_q <= 3'd0;
      presc_q     <= '0;
      ticks_q     <= '0;
      ack_q       <= 4'b0000;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      beep_en_q   <= 1'b0;
      tone_sel_q  <= 4'b0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tone_q      <= tone_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      ticks_q     <= ticks_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      beep_en_q   <= beep_en_d;
      tone_sel_q  <= tone_sel_d;
    end
  end

  assign ack_o      = ack_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;
  assign tone_sel_o = tone_sel_q;
  assign beep_en_o  = beep_en_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: scripted scenarios plus random traffic, checked
// every cycle against a pattern-timeline model kept in elapsed-cycle terms.
module tb_buzzer_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int ON_CYC    = ON_TICKS * TICK_DIV;
  localparam int PERIOD    = (ON_TICKS + OFF_TICKS) * TICK_DIV;

  logic        clk_sel   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  req_i       = 4'b0;
  logic [7:0]  req_tone_i  = 8'b0;
  logic [11:0] req_beeps_i = 12'b0;
  logic        abort_i     = 1'b0;
  logic [3:0]  ack_o;
  logic        busy_o;
  logic [1:0]  owner_o;
  logic [3:0]  tone_sel_o;
  logic        beep_en_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a pattern is just "N beeps started at some edge"; outputs
  // follow from how many cycles have elapsed since that grant.
  bit       mBusy;
  int       mElapsed;
  int       mLen;
  int       mTone;
  int       mOwner;
  logic [3:0] expAck;
  logic       expDone;

  buzzer_sequencer #(
    .TICK_DIV(TICK_DIV),
    .ON_TICKS(ON_TICKS),
    .OFF_TICKS(OFF_TICKS)
  ) dut (
    .clk_sel(clk_sel),
    .sys_rst_n(sys_rst_n),
    .req_i(req_i),
    .req_tone_i(req_tone_i),
    .req_beeps_i(req_beeps_i),
    .abort_i(abort_i),
    .ack_o(ack_o),
    .busy_o(busy_o),
    .owner_o(owner_o),
    .tone_sel_o(tone_sel_o),
    .beep_en_o(beep_en_o),
    .done_o(done_o)
  );

  always #5 clk_sel = ~clk_sel;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, expected);
    end
  endtask

  task automatic modelReset();
    mBusy    = 1'b0;
    mElapsed = 0;
    mLen     = 0;
    mTone    = 0;
    mOwner   = 0;
    expAck   = 4'b0;
    expDone  = 1'b0;
  endtask

  task automatic modelEdge();
    int win;
    int n;
    expAck  = 4'b0;
    expDone = 1'b0;
    if (mBusy) begin
      if (abort_i) begin
        mBusy = 1'b0;
      end else begin
        mElapsed++;
        if (mElapsed == mLen) begin
          mBusy   = 1'b0;
          expDone = 1'b1;
        end
      end
    end else if (req_i != 4'b0) begin
      win = 0;
      for (int i = 3; i >= 0; i--) if (req_i[i]) win = i;
      mOwner = win;
      mTone  = int'((req_tone_i >> (2 * win)) & 8'h3);
      n      = int'((req_beeps_i >> (3 * win)) & 12'h7);
      expAck = 4'b0001 << win;
      if (n != 0) begin
        mBusy    = 1'b1;
        mElapsed = 0;
        mLen     = n * PERIOD;
      end
    end
  endtask

  task automatic checkAll();
    bit   expBeep;
    logic [3:0] expTone;
    expBeep = mBusy && ((mElapsed % PERIOD) < ON_CYC);
    expTone = expBeep ? (4'b0001 << mTone) : 4'b0000;
    checkOutput("ack", 32'(ack_o), 32'(expAck));
    checkOutput("busy", 32'(busy_o), 32'(mBusy));
    checkOutput("owner", 32'(owner_o), 32'(mOwner));
    checkOutput("tone_sel", 32'(tone_sel_o), 32'(expTone));
    checkOutput("beep_en", 32'(beep_en_o), 32'(expBeep));
    checkOutput("done", 32'(done_o), 32'(expDone));
  endtask

  task automatic stepCycle();
    modelEdge();
    @(posedge clk_sel);
    #1;
    cyc++;
    checkAll();
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [7:0] tone,
                               input logic [11:0] beeps, input logic abort);
    req_i       = req;
    req_tone_i  = tone;
    req_beeps_i = beeps;
    abort_i     = abort;
  endtask

  task automatic runQuiet(input int n);
    applyStimulus(4'b0, req_tone_i, req_beeps_i, 1'b0);
    repeat (n) stepCycle();
  endtask

  task automatic doReset();
    sys_rst_n = 1'b0;
    applyStimulus(4'b0, 8'b0, 12'b0, 1'b0);
    #1;
    modelReset();
    checkAll();
    @(negedge clk_sel);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #3;
    doReset();
    repeat (2) stepCycle();

    // Single requester, tone 2, two beeps.
    applyStimulus(4'b0001, 8'h02, 12'o0002, 1'b0);
    stepCycle();
    runQuiet(45);

    // Simultaneous req[1] and req[3]; req[3] is held and re-granted after done.
    applyStimulus(4'b1010, 8'b11_00_01_00, {3'd1, 3'd0, 3'd1, 3'd0}, 1'b0);
    stepCycle();
    applyStimulus(4'b1000, req_tone_i, req_beeps_i, 1'b0);
    repeat (21) stepCycle();
    runQuiet(25);

    // Request from requester 2 arriving while a three-beep pattern runs.
    applyStimulus(4'b0001, 8'h01, {3'd1, 3'd1, 3'd1, 3'd3}, 1'b0);
    stepCycle();
    runQuiet(4);
    applyStimulus(4'b0100, req_tone_i, req_beeps_i, 1'b0);
    stepCycle();
    runQuiet(60);

    // Abort in the middle of a two-beep pattern, then an immediate new grant.
    applyStimulus(4'b0001, 8'h03, {3'd0, 3'd0, 3'd1, 3'd2}, 1'b0);
    stepCycle();
    runQuiet(14);
    applyStimulus(4'b0000, req_tone_i, req_beeps_i, 1'b1);
    stepCycle();
    applyStimulus(4'b0010, req_tone_i, req_beeps_i, 1'b0);
    stepCycle();
    runQuiet(25);

    // Zero-beep request: grant pulse only.
    applyStimulus(4'b1000, 8'hC0, 12'o0111, 1'b0);
    stepCycle();
    runQuiet(5);

    // Asynchronous reset during ON, then a fresh pattern on requester 2.
    applyStimulus(4'b0001, 8'h01, 12'o0002, 1'b0);
    stepCycle();
    runQuiet(5);
    #2;
    doReset();
    applyStimulus(4'b0100, 8'b00_11_00_00, {3'd0, 3'd1, 3'd0, 3'd0}, 1'b0);
    stepCycle();
    runQuiet(25);

    // Random traffic with occasional aborts.
    for (int k = 0; k < 3000; k++) begin
      logic [11:0] beeps;
      for (int s = 0; s < 4; s++) beeps[3*s +: 3] = 3'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0,
                    8'($urandom), beeps, ($urandom_range(0, 59) == 0));
      stepCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
